// File: rtl/micro_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : micro_seq_pkg
// Description : Shared types and constants for the micro-sequencer slice:
//               FSM state encoding, default halt opcode, dispatch bases.
// Revision    : 1.0 - initial release
// ============================================================================
package micro_seq_pkg;

  // Instruction-cycle states, 3-bit encoded
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } seq_state_t;

  // Opcode that stops the machine instead of dispatching
  localparam logic [3:0] c_HLT_OP_DEFAULT = 4'hF;

  // Opcodes below this limit dispatch to {opcode[2:0],1'b0}
  localparam int         c_DISP_LO_LIMIT  = 8;

  // Entry point shared by all opcodes at or above the limit
  localparam logic [3:0] c_DISP_HI_BASE   = 4'h0;

endpackage
`default_nettype wire

// File: rtl/micro_dispatch_rom.sv
`default_nettype none
// ============================================================================
// Module      : micro_dispatch_rom
// Description : Combinational opcode -> microprogram entry address table.
//               Kept separate so the map can grow with the instruction set.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_dispatch_rom
  import micro_seq_pkg::*;
#(
  parameter int UPC_W = 4,
  parameter int OP_W  = 4
) (
  input  logic [OP_W-1:0]  OPCODE,
  output logic [UPC_W-1:0] UPC_D
);

  // Low opcodes get two microsteps of room each; the rest share one entry
  always_comb begin
    UPC_D = UPC_W'(c_DISP_HI_BASE);
    if (OPCODE < OP_W'(c_DISP_LO_LIMIT)) begin
      UPC_D = UPC_W'({OPCODE[2:0], 1'b0});
    end
  end

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Instruction-cycle sequencer driving an external loadable
//               uPC counter, the IR load strobe and the memory request.
//               Only state and FAULT are registered; counter controls decode
//               straight from the current microinstruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int              UPC_W  = 4,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] HLT_OP = OP_W'(c_HLT_OP_DEFAULT)
) (
  input  logic             CLK,
  input  logic             CLRn,
  input  logic             START,
  input  logic             HALT_REQ,
  input  logic [OP_W-1:0]  OPCODE,
  input  logic             MEM_RDY,
  input  logic             COND,
  input  logic             UEND,
  input  logic             UBR,
  input  logic             UWAIT,
  input  logic [UPC_W-1:0] UTGT,
  input  logic [UPC_W-1:0] UPC_Q,
  output logic             UPC_LDn,
  output logic             UPC_ENP,
  output logic             UPC_ENT,
  output logic [UPC_W-1:0] UPC_D,
  output logic             MEM_REQ,
  output logic             IR_LD,
  output logic             BUSY,
  output logic             HALTED,
  output logic             FAULT
);

  localparam logic [UPC_W-1:0] c_UPC_LAST = '1;

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic             r_fault;
  logic             w_set_fault;
  logic [UPC_W-1:0] w_disp;

  micro_dispatch_rom #(
    .UPC_W (UPC_W),
    .OP_W  (OP_W)
  ) u_dispatch (
    .OPCODE (OPCODE),
    .UPC_D  (w_disp)
  );

  // State register; CLRn is shared with the uPC so both restart together
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Sticky overflow flag, only a reset clears it
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn)            r_fault <= 1'b0;
    else if (w_set_fault) r_fault <= 1'b1;
  end

  assign FAULT = r_fault;

  // Next-state and counter/memory control decode
  always_comb begin
    w_next      = r_state;
    w_set_fault = 1'b0;
    UPC_LDn     = 1'b1;
    UPC_ENP     = 1'b0;
    UPC_ENT     = 1'b0;
    UPC_D       = '0;
    MEM_REQ     = 1'b0;
    IR_LD       = 1'b0;
    BUSY        = 1'b0;
    HALTED      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = S_FETCH;
      end
      S_FETCH: begin
        BUSY    = 1'b1;
        MEM_REQ = 1'b1;
        if (MEM_RDY) begin
          IR_LD  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        BUSY = 1'b1;
        if (OPCODE == HLT_OP) begin
          w_next = S_HALT;
        end else begin
          UPC_LDn = 1'b0;
          UPC_D   = w_disp;
          w_next  = S_EXEC;
        end
      end
      S_EXEC: begin
        BUSY = 1'b1;
        if (UWAIT && !MEM_RDY) begin
          // ENT alone keeps the cascade primed while the uPC holds
          MEM_REQ = 1'b1;
          UPC_ENT = 1'b1;
        end else if (UEND) begin
          MEM_REQ = UWAIT;
          w_next  = HALT_REQ ? S_HALT : S_FETCH;
        end else if (UBR && COND) begin
          UPC_LDn = 1'b0;
          UPC_D   = UTGT;
        end else if (UPC_Q == c_UPC_LAST) begin
          // Counting past the last address would wrap into another routine
          w_set_fault = 1'b1;
          w_next      = S_HALT;
        end else begin
          UPC_ENP = 1'b1;
          UPC_ENT = 1'b1;
          MEM_REQ = UWAIT;
        end
      end
      S_HALT: begin
        HALTED = 1'b1;
        if (!r_fault && START) w_next = S_FETCH;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Self-checking bench for micro_sequencer with a behavioural
//               4-bit loadable counter standing in for the external uPC.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_micro_sequencer;

  logic       CLK, CLRn, START, HALT_REQ, MEM_RDY, COND, UEND, UBR, UWAIT;
  logic [3:0] OPCODE, UTGT, UPC_Q, UPC_D;
  logic       UPC_LDn, UPC_ENP, UPC_ENT, MEM_REQ, IR_LD, BUSY, HALTED, FAULT;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .CLK      (CLK),
    .CLRn     (CLRn),
    .START    (START),
    .HALT_REQ (HALT_REQ),
    .OPCODE   (OPCODE),
    .MEM_RDY  (MEM_RDY),
    .COND     (COND),
    .UEND     (UEND),
    .UBR      (UBR),
    .UWAIT    (UWAIT),
    .UTGT     (UTGT),
    .UPC_Q    (UPC_Q),
    .UPC_LDn  (UPC_LDn),
    .UPC_ENP  (UPC_ENP),
    .UPC_ENT  (UPC_ENT),
    .UPC_D    (UPC_D),
    .MEM_REQ  (MEM_REQ),
    .IR_LD    (IR_LD),
    .BUSY     (BUSY),
    .HALTED   (HALTED),
    .FAULT    (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External uPC: sync load (active-low), count on ENP&ENT, async clear
  always @(posedge CLK or negedge CLRn) begin
    if (!CLRn)            UPC_Q <= 4'h0;
    else if (!UPC_LDn)    UPC_Q <= UPC_D;
    else if (UPC_ENP && UPC_ENT) UPC_Q <= UPC_Q + 4'h1;
  end

  // in  = {START,HALT_REQ,MEM_RDY,COND,UEND,UBR,UWAIT}
  // ctl = {UPC_LDn,UPC_ENP,UPC_ENT,MEM_REQ,IR_LD,BUSY,HALTED,FAULT}
  typedef struct {
    logic [6:0] in;
    logic [3:0] op;
    logic [3:0] tg;
    logic [7:0] ctl;
    logic [3:0] d;
    logic [3:0] q;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [6:0] in, input logic [3:0] op, input logic [3:0] tg,
                     input logic [7:0] ctl, input logic [3:0] d, input logic [3:0] q);
    vec_t v;
    v.in = in; v.op = op; v.tg = tg; v.ctl = ctl; v.d = d; v.q = q;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] ctl, input logic [3:0] d,
                       input logic [3:0] q);
    logic [15:0] act, exp;
    act = {UPC_LDn, UPC_ENP, UPC_ENT, MEM_REQ, IR_LD, BUSY, HALTED, FAULT, UPC_D, UPC_Q};
    exp = {ctl, d, q};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: ctl/d/q got %b/%h/%h expected %b/%h/%h",
               name, act[15:8], act[7:4], act[3:0], ctl, d, q);
    end
  endtask

  task automatic set_in(input logic [6:0] in, input logic [3:0] op, input logic [3:0] tg);
    {START, HALT_REQ, MEM_RDY, COND, UEND, UBR, UWAIT} = in;
    OPCODE = op;
    UTGT   = tg;
  endtask

  // Advance one edge and settle inputs away from it
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main flow: dispatch op3, counting, wait, branch, halt, HLT op, overflow
    add(7'b1000000, 4'h0, 4'h0, 8'b10000000, 4'h0, 4'h0); // 0 IDLE, START
    add(7'b0010000, 4'h3, 4'h0, 8'b10011100, 4'h0, 4'h0); // 1 FETCH, RDY
    add(7'b0000000, 4'h3, 4'h0, 8'b00000100, 4'h6, 4'h0); // 2 DECODE op3
    add(7'b0000000, 4'h3, 4'h0, 8'b11100100, 4'h0, 4'h6); // 3 EXEC count
    add(7'b0000000, 4'h3, 4'h0, 8'b11100100, 4'h0, 4'h7); // 4 EXEC count
    add(7'b0000100, 4'h3, 4'h0, 8'b10000100, 4'h0, 4'h8); // 5 EXEC UEND
    add(7'b0000000, 4'h1, 4'h0, 8'b10010100, 4'h0, 4'h8); // 6 FETCH wait
    add(7'b0010000, 4'h1, 4'h0, 8'b10011100, 4'h0, 4'h8); // 7 FETCH RDY
    add(7'b0000000, 4'h1, 4'h0, 8'b00000100, 4'h2, 4'h8); // 8 DECODE op1
    add(7'b0000001, 4'h1, 4'h0, 8'b10110100, 4'h0, 4'h2); // 9 EXEC UWAIT stall
    add(7'b0000001, 4'h1, 4'h0, 8'b10110100, 4'h0, 4'h2); // 10 stall
    add(7'b0000001, 4'h1, 4'h0, 8'b10110100, 4'h0, 4'h2); // 11 stall
    add(7'b0010001, 4'h1, 4'h0, 8'b11110100, 4'h0, 4'h2); // 12 RDY -> count
    add(7'b0001010, 4'h1, 4'hC, 8'b00000100, 4'hC, 4'h3); // 13 branch taken
    add(7'b0100010, 4'h1, 4'hC, 8'b11100100, 4'h0, 4'hC); // 14 branch not taken, HALT_REQ
    add(7'b0100000, 4'h1, 4'h0, 8'b11100100, 4'h0, 4'hD); // 15 HALT_REQ ignored
    add(7'b0100100, 4'h1, 4'h0, 8'b10000100, 4'h0, 4'hE); // 16 UEND -> HALT
    add(7'b0000000, 4'h1, 4'h0, 8'b10000010, 4'h0, 4'hE); // 17 HALT holds
    add(7'b1000000, 4'h1, 4'h0, 8'b10000010, 4'h0, 4'hE); // 18 HALT START
    add(7'b0010000, 4'hF, 4'h0, 8'b10011100, 4'h0, 4'hE); // 19 FETCH HLT op
    add(7'b0000000, 4'hF, 4'h0, 8'b10000100, 4'h0, 4'hE); // 20 DECODE HLT, no load
    add(7'b1000000, 4'hF, 4'h0, 8'b10000010, 4'h0, 4'hE); // 21 HALT START
    add(7'b0010000, 4'h9, 4'h0, 8'b10011100, 4'h0, 4'hE); // 22 FETCH op9
    add(7'b0000000, 4'h9, 4'h0, 8'b00000100, 4'h0, 4'hE); // 23 DECODE op9 -> 0
    add(7'b0010101, 4'h9, 4'h0, 8'b10010100, 4'h0, 4'h0); // 24 UEND with UWAIT, RDY
    add(7'b0010000, 4'h7, 4'h0, 8'b10011100, 4'h0, 4'h0); // 25 FETCH op7
    add(7'b0000000, 4'h7, 4'h0, 8'b00000100, 4'hE, 4'h0); // 26 DECODE op7 -> E
    add(7'b0000000, 4'h7, 4'h0, 8'b11100100, 4'h0, 4'hE); // 27 count to F
    add(7'b0000000, 4'h7, 4'h0, 8'b10000100, 4'h0, 4'hF); // 28 overflow, no count
    add(7'b1000000, 4'h7, 4'h0, 8'b10000011, 4'h0, 4'hF); // 29 fault HALT, START ignored
    add(7'b1000000, 4'h7, 4'h0, 8'b10000011, 4'h0, 4'hF); // 30 still halted

    CLRn = 1'b0;
    set_in(7'b0000000, 4'h0, 4'h0);
    #12;
    check("reset_hold", 8'b10000000, 4'h0, 4'h0);
    @(posedge CLK);
    #2;
    CLRn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].in, tbl[i].op, tbl[i].tg);
      #1;
      check($sformatf("vec%0d", i), tbl[i].ctl, tbl[i].d, tbl[i].q);
      tick();
    end

    // Faulted HALT: only CLRn exits, and it clears FAULT
    set_in(7'b0000000, 4'h0, 4'h0);
    #1;
    check("fault_sticky", 8'b10000011, 4'h0, 4'hF);
    CLRn = 1'b0;
    #1;
    check("clr_from_fault", 8'b10000000, 4'h0, 4'h0);
    CLRn = 1'b1;
    tick();
    #1;
    check("idle_after_clr", 8'b10000000, 4'h0, 4'h0);

    // Async clear in the middle of a FETCH cycle, no clock edge involved
    set_in(7'b1000000, 4'h0, 4'h0);
    tick();
    set_in(7'b0000000, 4'h0, 4'h0);
    #1;
    check("fetch_pending", 8'b10010100, 4'h0, 4'h0);
    #2;
    CLRn = 1'b0;
    #1;
    check("async_clr_mid_fetch", 8'b10000000, 4'h0, 4'h0);
    tick();
    CLRn = 1'b1;
    tick();
    #1;
    check("idle_after_async", 8'b10000000, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Control-unit sequencer for the model computer's microprogram counter (uPC). The uPC is an external 4-bit loadable, cascadable counter.
- Runs the instruction cycle: fetch, then decode/dispatch, then execute microsteps.
- Drives the counter's load/enable pins, its parallel-load data, the instruction-register load strobe and the memory request.
- Sits between the control store (microinstruction fields in) and the uPC/IR/memory interface.

Parameters:
- UPC_W, 4, uPC width; all uPC-related ports use this width.
- OP_W, 4, opcode width.
- HLT_OP, 4'hF, opcode that halts the machine instead of dispatching.

Ports:
- CLK  input  1  system clock, rising edge.
- CLRn  input  1  asynchronous active-low reset.
- START  input  1  leave IDLE or a non-fault HALT.
- HALT_REQ  input  1  request halt at next instruction boundary.
- OPCODE  input  OP_W  opcode from IR.
- MEM_RDY  input  1  memory completes the current request.
- COND  input  1  branch condition from ALU flags.
- UEND  input  1  microinstruction field: last microstep.
- UBR  input  1  microinstruction field: conditional branch.
- UWAIT  input  1  microinstruction field: step needs MEM_RDY.
- UTGT  input  UPC_W  microinstruction field: branch target.
- UPC_Q  input  UPC_W  current uPC value.
- UPC_LDn  output  1  uPC parallel load, active-low.
- UPC_ENP  output  1  uPC count enable P.
- UPC_ENT  output  1  uPC count enable T.
- UPC_D  output  UPC_W  uPC load data.
- MEM_REQ  output  1  memory request.
- IR_LD  output  1  IR load strobe.
- BUSY  output  1  instruction cycle in progress.
- HALTED  output  1  in HALT state.
- FAULT  output  1  sticky uPC overflow error.

Behaviour:
- Structure: registered state plus registered FAULT. All other outputs decode combinationally from state and current inputs, so there is zero latency from a microinstruction field to its counter control.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Defaults in every state: UPC_LDn=1, ENP=0, ENT=0, UPC_D=0, MEM_REQ=0, IR_LD=0.
- Reset (CLRn=0, async, any state, mid-instruction included):
  - State goes to IDLE and FAULT=0.
  - Outputs take their defaults; BUSY=0, HALTED=0.
  - The uPC counter shares CLRn and clears with it.
- IDLE:
  - BUSY=0.
  - START=1 moves to FETCH at the next edge.
- FETCH:
  - BUSY=1, MEM_REQ=1.
  - If MEM_RDY=1: IR_LD=1 this cycle and move to DECODE. Otherwise stay, with no timeout.
- DECODE:
  - BUSY=1.
  - If OPCODE==HLT_OP: no load; move to HALT.
  - Otherwise: UPC_LDn=0, UPC_D=dispatch(OPCODE); move to EXEC.
- EXEC: BUSY=1. Priority, evaluated each cycle:
  1. UWAIT=1 and MEM_RDY=0: MEM_REQ=1, ENT=1, ENP=0. uPC holds; stay in EXEC.
  2. UEND=1: uPC holds. MEM_REQ=UWAIT. Move to HALT if HALT_REQ=1, else FETCH.
  3. UBR=1 and COND=1: UPC_LDn=0, UPC_D=UTGT; stay.
  4. UPC_Q all-ones: overflow. No count. Set FAULT=1 and move to HALT.
  5. Otherwise: ENP=ENT=1 (uPC increments); MEM_REQ=UWAIT; stay.
- UBR=1 with COND=0 falls through to the count rule.
- HALT_REQ is honoured only on the UEND transition.
- HALT:
  - HALTED=1, BUSY=0.
  - If FAULT=0: START=1 moves to FETCH.
  - If FAULT=1: only CLRn exits.
- Dispatch (fixed table):
  - Opcodes 0-7 map to uPC address {OPCODE[2:0],1'b0}.
  - Opcodes 8-14 map to 4'h0.
  - HLT_OP never dispatches.

Decomposition:
- Shared package/include micro_seq_pkg:
  - State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, 3-bit.
  - HLT_OP default.
  - Dispatch base constants.
- Sub-module micro_dispatch_rom: combinational OPCODE to UPC_D table, kept separate so it can be swapped when the instruction set grows.

Test Plan:
- Reset then START=1, MEM_RDY=1 next cycle, OPCODE=3 -> FETCH 1 cycle with IR_LD=1; DECODE asserts UPC_LDn=0, UPC_D=6; EXEC counts 6,7,8; UEND at Q=8 -> FETCH with ENP=0.
- EXEC at Q=2 with UWAIT=1, MEM_RDY low for 3 cycles -> MEM_REQ=1, ENP=0, ENT=1 for 3 cycles; on MEM_RDY=1, Q advances to 3.
- UBR=1: COND=1 with UTGT=4'hC -> UPC_LDn=0, UPC_D=C; COND=0 -> ENP=ENT=1, plain increment.
- HALT_REQ=1 during EXEC, UEND 2 cycles later -> HALT, HALTED=1, BUSY=0. START then gives FETCH. Also OPCODE=4'hF in DECODE -> HALT with no load.
- EXEC reaches UPC_Q=4'hF with no UEND/UBR -> FAULT=1, HALT; START ignored; CLRn pulse returns IDLE with FAULT=0.
- CLRn asserted mid-FETCH with MEM_REQ=1 -> all outputs drop to reset values immediately, without waiting for a clock edge.
